// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback, mult/div and register-file port bundle for wb_port_arbiter
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_addr;
  logic [31:0]   md_data;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          pipe_stall;
  logic          pend_hit;
  logic [CW-1:0] fifo_count;

  modport master (
    output wb_we, wb_addr, wb_data, md_valid, md_addr, md_data, rs_addr, rt_addr,
    input  md_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_hit, fifo_count
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, md_valid, md_addr, md_data, rs_addr, rt_addr,
    output md_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_hit, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between pipeline writeback and
// buffered mult/div results, with a starvation drain that stalls the pipeline for one slot.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {ST_NORMAL, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            stall_q, stall_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]      addr_q [DEPTH];
  logic [4:0]      addr_d [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];

  logic        md_ready;
  logic        head_present;
  logic        head_valid;
  logic        pipe_grant;
  logic        fifo_grant;
  logic        push;
  logic        pop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_hit;

  function automatic logic src_match(input logic [4:0] a, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return ((rs != 5'd0) && (a == rs)) || ((rt != 5'd0) && (a == rt));
  endfunction

  // Grant selection: the pipeline owns the port in NORMAL, the FIFO head owns it in DRAIN.
  always_comb begin
    md_ready     = !reset && (count_q < CW'(DEPTH));
    head_present = (count_q != '0);
    head_valid   = head_present && valid_q[rd_ptr_q];
    pipe_grant   = (state_q == ST_NORMAL) && bus.wb_we && (bus.wb_addr != 5'd0);
    fifo_grant   = head_valid && !pipe_grant;
    pop          = head_present && (fifo_grant || !valid_q[rd_ptr_q]);
    push         = bus.md_valid && md_ready && (bus.md_addr != 5'd0);

    rf_we    = pipe_grant || fifo_grant;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_grant) begin
      rf_waddr = bus.wb_addr;
      rf_wdata = bus.wb_data;
    end else if (fifo_grant) begin
      rf_waddr = addr_q[rd_ptr_q];
      rf_wdata = data_q[rd_ptr_q];
    end

    pend_hit = push && src_match(bus.md_addr, bus.rs_addr, bus.rt_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && src_match(addr_q[i], bus.rs_addr, bus.rt_addr)) begin
        pend_hit = 1'b1;
      end
    end
  end

  // The kill runs before the enqueue so a result arriving alongside the pipeline write survives.
  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (pipe_grant) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == bus.wb_addr) begin
          valid_d[i] = 1'b0;
        end
      end
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = bus.md_addr;
      data_d[wr_ptr_q]  = bus.md_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    case (state_q)
      ST_NORMAL: begin
        stall_d = 1'b0;
        if (head_valid && !fifo_grant) begin
          if (cnt_q == SW'(STARVE_LIMIT - 1)) begin
            state_d = ST_DRAIN;
            stall_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (fifo_grant || !head_present) begin
          cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Killed heads are popped silently; the stall lasts until one real write lands.
        if (fifo_grant || (count_d == '0)) begin
          state_d = ST_NORMAL;
          stall_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        stall_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_NORMAL;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign bus.md_ready   = md_ready;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.pipe_stall = stall_q;
  assign bus.pend_hit   = pend_hit;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed vectors, corner sequences and a queue-based reference model
module tb_wb_port_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic        e_pend;
    int          e_count;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  vec_t tbl [17];

  ent_t        mq[$];
  bit          m_drain;
  int          m_cnt;
  bit          x_we, x_pipe, x_fifo, x_push, x_ready, x_pend;
  logic [4:0]  x_waddr;
  logic [31:0] x_wdata;

  function automatic vec_t mkv(bit we, int wa, logic [31:0] wd, bit mv, int ma, logic [31:0] md,
                               int rs, int rt, bit ewe, int ewa, logic [31:0] ewd, bit erdy,
                               bit epend, int ecnt, bit estall);
    vec_t v;
    v.wb_we = we;   v.wb_addr = 5'(wa);  v.wb_data = wd;
    v.md_valid = mv; v.md_addr = 5'(ma); v.md_data = md;
    v.rs = 5'(rs);  v.rt = 5'(rt);
    v.e_we = ewe;   v.e_waddr = 5'(ewa); v.e_wdata = ewd;
    v.e_ready = erdy; v.e_pend = epend; v.e_count = ecnt; v.e_stall = estall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic compare_outputs(input string nm, input bit e_we, input logic [4:0] e_wa,
                                 input logic [31:0] e_wd, input bit e_rdy, input bit e_pend,
                                 input int e_cnt, input bit e_stall);
    chk({nm, ".rf_we"}, 32'(bus.rf_we), 32'(e_we));
    if (e_we) begin
      chk({nm, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(e_wa));
      chk({nm, ".rf_wdata"}, bus.rf_wdata, e_wd);
    end
    chk({nm, ".md_ready"}, 32'(bus.md_ready), 32'(e_rdy));
    chk({nm, ".pend_hit"}, 32'(bus.pend_hit), 32'(e_pend));
    chk({nm, ".fifo_count"}, 32'(bus.fifo_count), 32'(e_cnt));
    chk({nm, ".pipe_stall"}, 32'(bus.pipe_stall), 32'(e_stall));
  endtask

  task automatic drive(input vec_t v);
    bus.wb_we    = v.wb_we;
    bus.wb_addr  = v.wb_addr;
    bus.wb_data  = v.wb_data;
    bus.md_valid = v.md_valid;
    bus.md_addr  = v.md_addr;
    bus.md_data  = v.md_data;
    bus.rs_addr  = v.rs;
    bus.rt_addr  = v.rt;
  endtask

  task automatic apply(input vec_t v, input string nm);
    drive(v);
    @(negedge clk);
    compare_outputs(nm, v.e_we, v.e_waddr, v.e_wdata, v.e_ready, v.e_pend, v.e_count, v.e_stall);
    @(posedge clk);
    #1;
  endtask

  function automatic bit src_hit(logic [4:0] a);
    return ((bus.rs_addr != 0) && (a == bus.rs_addr)) || ((bus.rt_addr != 0) && (a == bus.rt_addr));
  endfunction

  // Reference: the FIFO is a plain queue; killed entries stay queued with v=0.
  task automatic model_eval();
    x_ready = (mq.size() < DEPTH);
    x_pipe  = !m_drain && bus.wb_we && (bus.wb_addr != 0);
    x_fifo  = !x_pipe && (mq.size() > 0) && mq[0].v;
    x_push  = bus.md_valid && x_ready && (bus.md_addr != 0);
    x_we    = x_pipe || x_fifo;
    x_waddr = x_pipe ? bus.wb_addr : (x_fifo ? mq[0].a : 5'd0);
    x_wdata = x_pipe ? bus.wb_data : (x_fifo ? mq[0].d : 32'd0);
    x_pend  = x_push && src_hit(bus.md_addr);
    foreach (mq[i]) if (mq[i].v && src_hit(mq[i].a)) x_pend = 1'b1;
  endtask

  task automatic model_commit();
    int n0 = mq.size();
    bit denied = (n0 > 0) && mq[0].v && !x_fifo;
    ent_t e;
    if ((n0 > 0) && (x_fifo || !mq[0].v)) void'(mq.pop_front());
    if (x_pipe) foreach (mq[i]) if (mq[i].a == bus.wb_addr) mq[i].v = 1'b0;
    if (x_push) begin
      e.a = bus.md_addr; e.d = bus.md_data; e.v = 1'b1;
      mq.push_back(e);
    end
    if (!m_drain) begin
      if (denied) begin
        if (m_cnt == STARVE_LIMIT - 1) begin
          m_drain = 1'b1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end else if (x_fifo || n0 == 0) begin
        m_cnt = 0;
      end
    end else if (x_fifo || mq.size() == 0) begin
      m_drain = 1'b0;
      m_cnt   = 0;
    end
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle   = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(idle);
    reset = 1'b1;

    @(negedge clk);
    chk("reset.md_ready", 32'(bus.md_ready), 32'd0);
    chk("reset.fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("reset.pipe_stall", 32'(bus.pipe_stall), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    //               we wa wd            mv ma md      rs  rt  ewe ewa ewd           rdy pnd cnt stl
    tbl[0]  = mkv(0, 0, 0,            0, 0,  0,      0,  0,  0, 0,  0,            1, 0, 0, 0);
    tbl[1]  = mkv(1, 5, 32'hA5A5A5A5, 0, 0,  0,      0,  0,  1, 5,  32'hA5A5A5A5, 1, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 0,            1, 9,  32'h1234, 9, 0, 0, 0,  0,            1, 1, 0, 0);
    tbl[3]  = mkv(0, 0, 0,            0, 0,  0,      9,  0,  1, 9,  32'h1234,     1, 1, 1, 0);
    tbl[4]  = mkv(0, 0, 0,            0, 0,  0,      9,  0,  0, 0,  0,            1, 0, 0, 0);
    tbl[5]  = mkv(1, 0, 32'hFFFF,     1, 0,  32'h55, 0,  0,  0, 0,  0,            1, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 0,            0, 0,  0,      0,  0,  0, 0,  0,            1, 0, 0, 0);
    tbl[7]  = mkv(1, 3, 32'hDDDD0003, 1, 10, 32'h10, 10, 12, 1, 3,  32'hDDDD0003, 1, 1, 0, 0);
    tbl[8]  = mkv(1, 3, 32'hDDDD0003, 1, 11, 32'h11, 10, 12, 1, 3,  32'hDDDD0003, 1, 1, 1, 0);
    tbl[9]  = mkv(1, 3, 32'hDDDD0003, 1, 12, 32'h12, 10, 12, 1, 3,  32'hDDDD0003, 0, 1, 2, 0);
    tbl[10] = mkv(1, 3, 32'hDDDD0003, 1, 12, 32'h12, 10, 12, 1, 3,  32'hDDDD0003, 0, 1, 2, 0);
    tbl[11] = mkv(1, 3, 32'hDDDD0003, 1, 12, 32'h12, 10, 12, 1, 3,  32'hDDDD0003, 0, 1, 2, 0);
    tbl[12] = mkv(1, 3, 32'hDDDD0003, 1, 12, 32'h12, 10, 12, 1, 10, 32'h10,       0, 1, 2, 1);
    tbl[13] = mkv(1, 3, 32'hDDDD0003, 1, 12, 32'h12, 0,  12, 1, 3,  32'hDDDD0003, 1, 1, 1, 0);
    tbl[14] = mkv(0, 0, 0,            0, 0,  0,      0,  12, 1, 11, 32'h11,       0, 1, 2, 0);
    tbl[15] = mkv(0, 0, 0,            0, 0,  0,      0,  12, 1, 12, 32'h12,       1, 1, 1, 0);
    tbl[16] = mkv(0, 0, 0,            0, 0,  0,      0,  12, 0, 0,  0,            1, 0, 0, 0);
    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // WAW kill of a buffered r7, then the dead head is popped without a write.
    apply(mkv(1, 3, 32'h33,   1, 7, 32'h7777, 7, 0, 1, 3, 32'h33,   1, 1, 0, 0), "kill0");
    apply(mkv(1, 7, 32'hBEEF, 0, 0, 0,        7, 0, 1, 7, 32'hBEEF, 1, 1, 1, 0), "kill1");
    apply(mkv(0, 0, 0,        0, 0, 0,        7, 0, 0, 0, 0,        1, 0, 1, 0), "kill2");
    apply(mkv(0, 0, 0,        0, 0, 0,        7, 0, 0, 0, 0,        1, 0, 0, 0), "kill3");

    // A result arriving in the same cycle as a pipeline write to the same register survives.
    apply(mkv(1, 8, 32'h88, 1, 8, 32'h8888, 8, 0, 1, 8, 32'h88,   1, 1, 0, 0), "nokill0");
    apply(mkv(0, 0, 0,      0, 0, 0,        8, 0, 1, 8, 32'h8888, 1, 1, 1, 0), "nokill1");
    apply(mkv(0, 0, 0,      0, 0, 0,        8, 0, 0, 0, 0,        1, 0, 0, 0), "nokill2");

    // Reset while draining with two buffered entries.
    apply(mkv(1, 3, 32'h3, 1, 10, 32'h10, 0, 0, 1, 3, 32'h3, 1, 0, 0, 0), "rst0");
    apply(mkv(1, 3, 32'h3, 1, 11, 32'h11, 0, 0, 1, 3, 32'h3, 1, 0, 1, 0), "rst1");
    apply(mkv(1, 3, 32'h3, 0, 0,  0,      0, 0, 1, 3, 32'h3, 0, 0, 2, 0), "rst2");
    apply(mkv(1, 3, 32'h3, 0, 0,  0,      0, 0, 1, 3, 32'h3, 0, 0, 2, 0), "rst3");
    apply(mkv(1, 3, 32'h3, 0, 0,  0,      0, 0, 1, 3, 32'h3, 0, 0, 2, 0), "rst4");
    chk("rst.drain_stall", 32'(bus.pipe_stall), 32'd1);
    chk("rst.drain_count", 32'(bus.fifo_count), 32'd2);
    drive(idle);
    reset = 1'b1;
    #2;
    chk("rst.in_reset_count", 32'(bus.fifo_count), 32'd0);
    chk("rst.in_reset_stall", 32'(bus.pipe_stall), 32'd0);
    chk("rst.in_reset_ready", 32'(bus.md_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.after_ready", 32'(bus.md_ready), 32'd1);
    chk("rst.after_count", 32'(bus.fifo_count), 32'd0);
    @(posedge clk);
    #1;

    mq.delete();
    m_drain = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.wb_we    = ($urandom_range(0, 9) < 6);
      bus.wb_addr  = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom();
      bus.md_valid = ($urandom_range(0, 1) == 1);
      bus.md_addr  = 5'($urandom_range(0, 7));
      bus.md_data  = $urandom();
      bus.rs_addr  = 5'($urandom_range(0, 7));
      bus.rt_addr  = 5'($urandom_range(0, 7));
      @(negedge clk);
      model_eval();
      compare_outputs($sformatf("rnd%0d", i), x_we, x_waddr, x_wdata, x_ready, x_pend,
                      mq.size(), m_drain);
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
